// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer execution unit between RS issue and the CDB.
// Each op is computed at issue, carried through STAGES-1 payload registers,
// then queued in an OBUF_DEPTH-entry result FIFO until the CDB grants.
// Issue is credit-limited so the FIFO can never overflow.
// Optional feature macro: ALU_MUL_EN enables RV32M multiply on ARITH with func7_0=1.
module alu_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ROB_POS_W  = 4,
  parameter int STAGES     = 2,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_en,
  output logic                 alu_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic                 func1,
  input  logic                 func7_0,
  input  logic [DATA_W-1:0]    val1,
  input  logic [DATA_W-1:0]    val2,
  input  logic [DATA_W-1:0]    imm,
  input  logic [ADDR_W-1:0]    pc,
  input  logic [ROB_POS_W-1:0] rob_pos,
  input  logic                 cdb_grant,
  output logic                 result,
  output logic [ROB_POS_W-1:0] result_rob_pos,
  output logic [DATA_W-1:0]    result_val,
  output logic                 result_jump,
  output logic [ADDR_W-1:0]    result_pc
);
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // The FIFO write itself is the last of the STAGES registers.
  localparam int PIPE_N = STAGES - 1;
  localparam int PTR_W  = $clog2(OBUF_DEPTH);
  localparam int CNT_W  = $clog2(OBUF_DEPTH + STAGES + 1);

  logic [DATA_W-1:0]    calc2, alu_out, sra_out, calc_val;
  logic [ADDR_W-1:0]    pc_seq, calc_pc;
  logic                 calc_jump, br_taken;
  logic                 issue_fire, push_en, pop_en;
  logic                 push_v, push_jump;
  logic [ROB_POS_W-1:0] push_rob;
  logic [DATA_W-1:0]    push_val;
  logic [ADDR_W-1:0]    push_pc;
  logic [CNT_W-1:0]     inflight;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       fifo_count;
  logic [ROB_POS_W-1:0] mem_rob  [OBUF_DEPTH];
  logic [DATA_W-1:0]    mem_val  [OBUF_DEPTH];
  logic                 mem_jump [OBUF_DEPTH];
  logic [ADDR_W-1:0]    mem_pc   [OBUF_DEPTH];

  assign calc2   = (opcode == OP_ARITH) ? val2 : imm;
  assign sra_out = $signed(val1) >>> calc2[4:0];
  assign pc_seq  = pc + ADDR_W'(4);

`ifdef ALU_MUL_EN
  logic [2*DATA_W-1:0] mul_a, mul_b, mul_p;
  // MULHU zero-extends rs1; only MULH sign-extends rs2. Low word is signedness-independent.
  assign mul_a = (func3 == 3'b011) ? {{DATA_W{1'b0}}, val1} : {{DATA_W{val1[DATA_W-1]}}, val1};
  assign mul_b = (func3 == 3'b001) ? {{DATA_W{val2[DATA_W-1]}}, val2} : {{DATA_W{1'b0}}, val2};
  assign mul_p = mul_a * mul_b;
`else
  logic unused_func7;
  assign unused_func7 = func7_0;
`endif

  // Integer ALU for ARITH/ARITHI, optionally overridden by the multiplier
  always_comb begin
    alu_out = '0;
    case (func3)
      3'b000: alu_out = (opcode == OP_ARITH && func1) ? val1 - calc2 : val1 + calc2;
      3'b001: alu_out = val1 << calc2[4:0];
      3'b010: alu_out = {{(DATA_W-1){1'b0}}, ($signed(val1) < $signed(calc2))};
      3'b011: alu_out = {{(DATA_W-1){1'b0}}, (val1 < calc2)};
      3'b100: alu_out = val1 ^ calc2;
      3'b101: alu_out = func1 ? sra_out : (val1 >> calc2[4:0]);
      3'b110: alu_out = val1 | calc2;
      3'b111: alu_out = val1 & calc2;
      default: alu_out = '0;
    endcase
`ifdef ALU_MUL_EN
    if (opcode == OP_ARITH && func7_0) begin
      case (func3)
        3'b000:                 alu_out = mul_p[DATA_W-1:0];
        3'b001, 3'b010, 3'b011: alu_out = mul_p[2*DATA_W-1:DATA_W];
        default:                alu_out = '0;
      endcase
    end
`endif
  end

  // Branch condition evaluation on rs1/rs2
  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000: br_taken = (val1 == val2);
      3'b001: br_taken = (val1 != val2);
      3'b100: br_taken = ($signed(val1) <  $signed(val2));
      3'b101: br_taken = ($signed(val1) >= $signed(val2));
      3'b110: br_taken = (val1 <  val2);
      3'b111: br_taken = (val1 >= val2);
      default: br_taken = 1'b0;
    endcase
  end

  // Select rd value, redirect flag and next pc per opcode
  always_comb begin
    calc_val  = '0;
    calc_jump = 1'b0;
    calc_pc   = pc_seq;
    case (opcode)
      OP_ARITH, OP_ARITHI: calc_val = alu_out;
      OP_BR: begin
        calc_jump = br_taken;
        if (br_taken) calc_pc = pc + ADDR_W'(imm);
      end
      OP_LUI:   calc_val = imm;
      OP_AUIPC: calc_val = DATA_W'(pc) + imm;
      OP_JAL: begin
        calc_val  = DATA_W'(pc_seq);
        calc_jump = 1'b1;
        calc_pc   = pc + ADDR_W'(imm);
      end
      OP_JALR: begin
        calc_val  = DATA_W'(pc_seq);
        calc_jump = 1'b1;
        calc_pc   = ADDR_W'(val1 + imm) & ~ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign issue_fire = alu_en & alu_ready & rdy & ~rollback;

  generate
    if (PIPE_N == 0) begin : g_direct
      assign push_v    = issue_fire;
      assign push_rob  = rob_pos;
      assign push_val  = calc_val;
      assign push_jump = calc_jump;
      assign push_pc   = calc_pc;
      assign inflight  = '0;
    end else begin : g_stages
      logic [PIPE_N-1:0]    st_v;
      logic [ROB_POS_W-1:0] st_rob  [PIPE_N];
      logic [DATA_W-1:0]    st_val  [PIPE_N];
      logic                 st_jump [PIPE_N];
      logic [ADDR_W-1:0]    st_pc   [PIPE_N];

      // Stage valids: flushed on rst/rollback, otherwise shift one stage per enabled cycle
      always_ff @(posedge clk) begin
        if (rst || rollback) begin
          st_v <= '0;
        end else if (rdy) begin
          st_v[0] <= issue_fire;
          for (int i = 1; i < PIPE_N; i++) st_v[i] <= st_v[i-1];
        end
      end

      // Stage payloads follow the valids; they need no reset because the valids qualify them
      always_ff @(posedge clk) begin
        if (rdy) begin
          st_rob[0]  <= rob_pos;
          st_val[0]  <= calc_val;
          st_jump[0] <= calc_jump;
          st_pc[0]   <= calc_pc;
          for (int i = 1; i < PIPE_N; i++) begin
            st_rob[i]  <= st_rob[i-1];
            st_val[i]  <= st_val[i-1];
            st_jump[i] <= st_jump[i-1];
            st_pc[i]   <= st_pc[i-1];
          end
        end
      end

      assign push_v    = st_v[PIPE_N-1];
      assign push_rob  = st_rob[PIPE_N-1];
      assign push_val  = st_val[PIPE_N-1];
      assign push_jump = st_jump[PIPE_N-1];
      assign push_pc   = st_pc[PIPE_N-1];
      assign inflight  = CNT_W'($countones(st_v));
    end
  endgenerate

  assign push_en = push_v & rdy & ~rollback;
  assign pop_en  = result & cdb_grant & rdy & ~rollback;

  // FIFO pointers and occupancy: flush on rst/rollback, push/pop only when enabled
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (rdy) begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Result storage written at the tail on push
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_rob[wr_ptr]  <= push_rob;
      mem_val[wr_ptr]  <= push_val;
      mem_jump[wr_ptr] <= push_jump;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end

  // Credits are conservative: a pop in this same cycle is not counted.
  assign alu_ready = (CNT_W'(fifo_count) + inflight) < CNT_W'(OBUF_DEPTH);

  assign result         = (fifo_count != '0);
  assign result_rob_pos = result ? mem_rob[rd_ptr]  : '0;
  assign result_val     = result ? mem_val[rd_ptr]  : '0;
  assign result_jump    = result ? mem_jump[rd_ptr] : 1'b0;
  assign result_pc      = result ? mem_pc[rd_ptr]   : '0;

  // The credit scheme must never deliver a push into a full FIFO without a matching pop
  assert property (@(posedge clk) disable iff (rst)
    !(push_en && !pop_en && (fifo_count == (PTR_W+1)'(OBUF_DEPTH))));

endmodule
